// File: rtl/jk_sync_counter_if.sv
// Bus bundle for jk_sync_counter: count controls in, count state out.
interface jk_sync_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, d,
        input  q, qbar, tc, wrap
    );

    modport slave (
        input  en, up, load, d,
        output q, qbar, tc, wrap
    );
endinterface

// File: rtl/jk_sync_counter.sv
// Up/down modulo-N counter built from JK cells steered into
// hold/toggle for counting and set/reset for load and correction.
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic              clk,
    input logic              rst_n,
    jk_sync_counter_if.slave bus
);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("jk_sync_counter: MODULUS out of range");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             force_mode;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_zero;
    logic             oor;

    assign at_top  = (q_r == TOP);
    assign at_zero = (q_r == '0);
    assign oor     = ({1'b0, q_r} >= MOD_X);

    always_comb begin
        nxt        = q_r;
        wrap_nxt   = 1'b0;
        force_mode = 1'b0;
        if (bus.load) begin
            force_mode = 1'b1;
            nxt = ({1'b0, bus.d} >= MOD_X) ? TOP : bus.d;
        end else if (bus.en) begin
            if (oor) begin
                force_mode = 1'b1;
                nxt = '0;
            end else if (bus.up) begin
                nxt      = at_top ? '0 : q_r + WIDTH'(1);
                wrap_nxt = at_top;
            end else begin
                nxt      = at_zero ? TOP : q_r - WIDTH'(1);
                wrap_nxt = at_zero;
            end
        end
    end

    // Counting uses J=K=T; load/correction drive J=D, K=~D per cell.
    assign tgl = q_r ^ nxt;
    assign j   = force_mode ? nxt  : tgl;
    assign k   = force_mode ? ~nxt : tgl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= (j & ~q_r) | (~k & q_r);
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.qbar = ~q_r;
    assign bus.wrap = wrap_r;
    assign bus.tc   = bus.en & ~bus.load
                    & ((bus.up & at_top) | (~bus.up & at_zero));
endmodule
